// File: rtl/minirv_pkg.sv
// Shared definitions for the multi-cycle miniRV core: opcodes, ALU operations,
// FSM states, immediate formats and the immediate generator.
package minirv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_PASSB
    } aluOp_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } immFmt_t;

    function automatic logic [31:0] genImm(input logic [31:0] ir, input immFmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   imm = {ir[31:12], 12'b0};
            IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/minirv_mc_alu.sv
// Combinational ALU for the multi-cycle core; eq/lt are signed comparisons of a and b
// used by the branch unit.
module minirv_mc_alu
    import minirv_pkg::*;
(
    input  aluOp_t      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        eq_o,
    output logic        lt_o
);

    always_comb begin
        result_o = 32'b0;
        case (op_i)
            ALU_ADD:   result_o = a_i + b_i;
            ALU_SUB:   result_o = a_i - b_i;
            ALU_AND:   result_o = a_i & b_i;
            ALU_OR:    result_o = a_i | b_i;
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_SLL:   result_o = a_i << b_i[4:0];
            ALU_SRL:   result_o = a_i >> b_i[4:0];
            ALU_SRA:   result_o = $signed(a_i) >>> b_i[4:0];
            ALU_PASSB: result_o = b_i;
            default:   result_o = 32'b0;
        endcase
    end

    assign eq_o = (a_i == b_i);
    assign lt_o = ($signed(a_i) < $signed(b_i));

endmodule

// File: rtl/minirv_multicycle.sv
// Multi-cycle miniRV core: FETCH/DECODE/EXEC/MEM/WB FSM with req/ack memory ports,
// configurable register-file depth and reset vector, halting on illegal instructions.
module minirv_multicycle
    import minirv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREG     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  wR,
    output logic [31:0] wD,
    output logic        retire,
    output logic        halted
);

    localparam int AW = $clog2(NREG);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] regA_q, regA_d;
    logic [31:0] regB_q, regB_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] aluRes_q, aluRes_d;
    logic [31:0] memData_q, memData_d;
    logic        rfWe_q, rfWe_d;
    logic [4:0]  wR_q, wR_d;
    logic [31:0] wD_q, wD_d;
    logic        retire_q, retire_d;

    logic [31:0] rf [NREG];
    logic        rfWrite;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic        legal, usesRs1, usesRs2, usesRd, useRegB;
    immFmt_t     immFmt;
    aluOp_t      aluOp;
    logic        isBranch, isLoad, isStore, isJal, isJalr;
    logic        taken;

    logic [31:0] aluB, aluResult;
    logic        aluEq, aluLt;
    logic [31:0] pcPlus4, wbData;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign isBranch = (opcode == OP_BRANCH);
    assign isLoad   = (opcode == OP_LOAD);
    assign isStore  = (opcode == OP_STORE);
    assign isJal    = (opcode == OP_JAL);
    assign isJalr   = (opcode == OP_JALR);

    // Register-index legality is checked only on the fields a format actually uses,
    // since e.g. the U/J immediates overlap the rs1/rs2 fields.
    always_comb begin
        legal   = 1'b0;
        usesRs1 = 1'b0;
        usesRs2 = 1'b0;
        usesRd  = 1'b0;
        useRegB = 1'b0;
        immFmt  = IMM_I;
        aluOp   = ALU_ADD;
        case (opcode)
            OP_REG: begin
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
                usesRd  = 1'b1;
                useRegB = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: begin legal = 1'b1; aluOp = ALU_ADD; end
                    {7'h20, 3'b000}: begin legal = 1'b1; aluOp = ALU_SUB; end
                    {7'h00, 3'b111}: begin legal = 1'b1; aluOp = ALU_AND; end
                    {7'h00, 3'b110}: begin legal = 1'b1; aluOp = ALU_OR;  end
                    {7'h00, 3'b100}: begin legal = 1'b1; aluOp = ALU_XOR; end
                    {7'h00, 3'b001}: begin legal = 1'b1; aluOp = ALU_SLL; end
                    {7'h00, 3'b101}: begin legal = 1'b1; aluOp = ALU_SRL; end
                    {7'h20, 3'b101}: begin legal = 1'b1; aluOp = ALU_SRA; end
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                usesRs1 = 1'b1;
                usesRd  = 1'b1;
                case (funct3)
                    3'b000: begin legal = 1'b1; aluOp = ALU_ADD; end
                    3'b100: begin legal = 1'b1; aluOp = ALU_XOR; end
                    3'b110: begin legal = 1'b1; aluOp = ALU_OR;  end
                    3'b111: begin legal = 1'b1; aluOp = ALU_AND; end
                    3'b001: begin legal = (funct7 == 7'h00); aluOp = ALU_SLL; end
                    3'b101: begin
                        legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                        aluOp = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                legal   = (funct3 == 3'b010);
                usesRs1 = 1'b1;
                usesRd  = 1'b1;
            end
            OP_STORE: begin
                legal   = (funct3 == 3'b010);
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
                immFmt  = IMM_S;
            end
            OP_BRANCH: begin
                legal   = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                          (funct3 == 3'b100) || (funct3 == 3'b101);
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
                useRegB = 1'b1;
                immFmt  = IMM_B;
                aluOp   = ALU_SUB;
            end
            OP_JAL: begin
                legal  = 1'b1;
                usesRd = 1'b1;
                immFmt = IMM_J;
            end
            OP_JALR: begin
                legal   = (funct3 == 3'b000);
                usesRs1 = 1'b1;
                usesRd  = 1'b1;
            end
            OP_LUI: begin
                legal  = 1'b1;
                usesRd = 1'b1;
                immFmt = IMM_U;
                aluOp  = ALU_PASSB;
            end
            default: legal = 1'b0;
        endcase
        if (NREG < 32 && ((usesRs1 && rs1[4]) || (usesRs2 && rs2[4]) || (usesRd && rd[4]))) begin
            legal = 1'b0;
        end
    end

    assign aluB = useRegB ? regB_q : imm_q;

    minirv_mc_alu u_alu (
        .op_i     (aluOp),
        .a_i      (regA_q),
        .b_i      (aluB),
        .result_o (aluResult),
        .eq_o     (aluEq),
        .lt_o     (aluLt)
    );

    always_comb begin
        case (funct3)
            3'b000:  taken = aluEq;
            3'b001:  taken = !aluEq;
            3'b100:  taken = aluLt;
            3'b101:  taken = !aluLt;
            default: taken = 1'b0;
        endcase
    end

    assign pcPlus4 = pc_q + 32'd4;
    assign wbData  = (isJal || isJalr) ? pcPlus4 : (isLoad ? memData_q : aluResult_or_latched());

    function automatic logic [31:0] aluResult_or_latched();
        return aluRes_q;
    endfunction

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        regA_d    = regA_q;
        regB_d    = regB_q;
        imm_d     = imm_q;
        aluRes_d  = aluRes_q;
        memData_d = memData_q;
        rfWe_d    = 1'b0;
        wR_d      = wR_q;
        wD_d      = wD_q;
        retire_d  = 1'b0;
        rfWrite   = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                regA_d  = (rs1 == 5'd0) ? 32'b0 : rf[rs1[AW-1:0]];
                regB_d  = (rs2 == 5'd0) ? 32'b0 : rf[rs2[AW-1:0]];
                imm_d   = genImm(ir_q, immFmt);
                state_d = legal ? EXEC : HALT;
            end
            EXEC: begin
                aluRes_d = aluResult;
                if (isBranch) begin
                    pc_d     = taken ? (pc_q + imm_q) : pcPlus4;
                    retire_d = 1'b1;
                    state_d  = FETCH;
                end else if (isLoad || isStore) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    if (isStore) begin
                        pc_d     = pcPlus4;
                        retire_d = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        memData_d = dmem_rdata;
                        state_d   = WB;
                    end
                end
            end
            WB: begin
                if (rd != 5'd0) begin
                    rfWrite = rst_n;
                    rfWe_d  = 1'b1;
                    wR_d    = rd;
                    wD_d    = wbData;
                end
                retire_d = 1'b1;
                if (isJal) begin
                    pc_d = pc_q + imm_q;
                end else if (isJalr) begin
                    pc_d = aluRes_q & ~32'd1;
                end else begin
                    pc_d = pcPlus4;
                end
                state_d = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'b0;
            regA_q    <= 32'b0;
            regB_q    <= 32'b0;
            imm_q     <= 32'b0;
            aluRes_q  <= 32'b0;
            memData_q <= 32'b0;
            rfWe_q    <= 1'b0;
            wR_q      <= 5'b0;
            wD_q      <= 32'b0;
            retire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            regA_q    <= regA_d;
            regB_q    <= regB_d;
            imm_q     <= imm_d;
            aluRes_q  <= aluRes_d;
            memData_q <= memData_d;
            rfWe_q    <= rfWe_d;
            wR_q      <= wR_d;
            wD_q      <= wD_d;
            retire_q  <= retire_d;
        end
    end

    // The register file is deliberately left unreset; software initialises what it reads.
    always_ff @(posedge clk) begin
        if (rfWrite) begin
            rf[rd[AW-1:0]] <= wbData;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_we    = (state_q == MEM) && isStore;
    assign dmem_addr  = aluRes_q;
    assign dmem_wdata = regB_q;
    assign rf_we      = rfWe_q;
    assign wR         = wR_q;
    assign wD         = wD_q;
    assign retire     = retire_q;
    assign halted     = (state_q == HALT);

endmodule
